monopulse_comparator: RTL and testbench
=======================================

# monopulse_comparator

Upstream front end of the monopulse angle path. Takes paired samples from antenna channels A and B and forms the sum (reference) and difference (error) streams that the monopulse relation stage consumes. Optionally block-averages over 2^AVG_LOG2 accepted samples to reduce noise. Results are saturated to DATA_SIZE bits and qualified by a one-cycle valid pulse.

## Interface
- DATA_SIZE, 64, width of channel samples and of reference/error outputs; all values are two's-complement signed
- AVG_LOG2, 2, log2 of the block-average length; 0 gives one output per input sample
- i_clock  in  1  single clock; all state changes on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  qualifies i_channel_a/i_channel_b in this cycle
- i_channel_a  in  DATA_SIZE  channel A sample, signed
- i_channel_b  in  DATA_SIZE  channel B sample, signed
- i_clear  in  1  synchronous flush of the pipeline and the partial average block
- o_reference  out  DATA_SIZE  saturated average of (A+B)
- o_error  out  DATA_SIZE  saturated average of (A−B)
- o_valid  out  1  one-cycle pulse; o_reference/o_error are new this cycle
- o_saturated  out  1  meaningful only while o_valid is high; set if either output was clamped

## Operation
- Stage 1: on each edge with i_valid=1 and i_clear=0, register sum=A+B and diff=A−B at DATA_SIZE+1 bits, sign-extended with no wrap. Register a stage-1 valid flag.
- Stage 2: accumulators of width DATA_SIZE+1+AVG_LOG2 plus a sample counter running 0..2^AVG_LOG2−1.
- When stage-1 valid is set and the counter is not at its last value: add sum/diff to the accumulators and increment the counter.
- When stage-1 valid is set and the counter is at its last value:
  - total = accumulator + current value;
  - result = total arithmetic-shifted right by AVG_LOG2 (floor toward −∞);
  - clamp result to [−2^(DATA_SIZE−1), 2^(DATA_SIZE−1)−1];
  - load o_reference/o_error, pulse o_valid, set o_saturated if either value clamped;
  - zero the accumulators and the counter.
- AVG_LOG2=0: every sample completes a block.
- o_reference, o_error and o_saturated hold their values between o_valid pulses.
- i_clear: on that edge, zero the stage-1 valid flag, accumulators and counter. o_valid is 0 on the following cycle. A sample presented with i_valid in the same cycle as i_clear is dropped. o_reference/o_error keep their last values.
- Gaps in i_valid are allowed anywhere. Only accepted samples count toward a block.

## Timing
- Reset (i_reset=0): asynchronously forces o_reference=0, o_error=0, o_valid=0, o_saturated=0, and clears accumulators, counter and stage-1 valid. Applies mid-block; the partial block is discarded.
- Latency: if the last sample of a block is accepted at edge N, o_valid is high in the cycle after edge N+1, i.e. 2 clocks.
- Throughput: one sample per clock, with no back-pressure. o_valid can pulse on consecutive cycles when AVG_LOG2=0.
- The first sample accepted after reset or after i_clear starts a new block.

## Test plan
- Reset: hold i_reset=0 with random inputs → all outputs 0. Release, then drive no i_valid → o_valid stays 0.
- DATA_SIZE=8, AVG_LOG2=0: A=10, B=3 at edge N → o_valid after edge N+1 with o_reference=13, o_error=7, o_saturated=0. Back-to-back samples give back-to-back pulses.
- Saturation, DATA_SIZE=8, AVG_LOG2=0:
  - A=100, B=100 → o_reference=127, o_error=0, o_saturated=1.
  - A=−128, B=100 → o_reference=−28, o_error=−128, o_saturated=1.
- Averaging, DATA_SIZE=8, AVG_LOG2=2: (4,0), (8,0), (12,0), (16,2) → a single pulse with o_reference=10, o_error=9. Diffs of −1, −1, −1, 0 → o_error=−1 (floor).
- Same block with idle cycles between samples → identical values, with o_valid 2 clocks after the 4th accepted sample. No pulse after the 1st–3rd samples.
- Flush and reset mid-block:
  - Two samples, then i_clear together with a valid sample → that sample is dropped and no pulse occurs. The next 4 samples form a fresh block with the correct average.
  - Asserting i_reset mid-block zeros all outputs; the next block is computed from post-reset samples only.

Source files
------------

// File: rtl/monopulse_comparator_if.sv
// Sample/result bundle for the monopulse sum/difference front end.
// Inputs carry paired A/B samples; outputs carry the averaged, saturated result.
interface monopulse_comparator_if #(
  parameter int DATA_SIZE = 64
);
  // Handshake: i_valid qualifies i_channel_a/i_channel_b in the same cycle, and there is
  // no back-pressure. o_valid is a one-cycle pulse marking a new o_reference/o_error/o_saturated.
  logic                 i_valid;
  logic [DATA_SIZE-1:0] i_channel_a;
  logic [DATA_SIZE-1:0] i_channel_b;
  logic                 i_clear;
  logic [DATA_SIZE-1:0] o_reference;
  logic [DATA_SIZE-1:0] o_error;
  logic                 o_valid;
  logic                 o_saturated;

  modport slave (
    input  i_valid, i_channel_a, i_channel_b, i_clear,
    output o_reference, o_error, o_valid, o_saturated
  );

  modport master (
    output i_valid, i_channel_a, i_channel_b, i_clear,
    input  o_reference, o_error, o_valid, o_saturated
  );
endinterface

// File: rtl/monopulse_comparator.sv
// Forms sum (A+B) and difference (A-B) streams, block-averages them over 2^AVG_LOG2
// accepted samples, and emits saturated results with a one-cycle valid pulse.
module monopulse_comparator #(
  parameter int DATA_SIZE = 64,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  monopulse_comparator_if.slave bus
);
  localparam int SW = DATA_SIZE + 1;
  localparam int AW = SW + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic signed [SW-1:0]   sum_q, sum_d, diff_q, diff_d;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [AW-1:0]   acc_sum_q, acc_sum_d, acc_diff_q, acc_diff_d;
  logic signed [AW-1:0]   tot_sum, tot_diff, res_sum, res_diff;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   ref_q, ref_d, err_q, err_d;
  logic [DATA_SIZE-1:0]   clip_sum, clip_diff;
  logic                   sat_sum, sat_diff;
  logic                   valid_q, valid_d, sat_q, sat_d;

  // Returns {clamped, value}: the value fits when all bits from the DATA_SIZE-1 sign
  // position upward agree; otherwise it goes to the rail matching its sign.
  function automatic logic [DATA_SIZE:0] clamp(input logic signed [AW-1:0] v);
    logic [AW-DATA_SIZE:0] top;
    top = v[AW-1:DATA_SIZE-1];
    if ((&top) || !(|top))
      return {1'b0, v[DATA_SIZE-1:0]};
    else if (v[AW-1])
      return {1'b1, 1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DATA_SIZE-1){1'b1}}};
  endfunction

  always_comb begin
    sum_d      = sum_q;
    diff_d     = diff_q;
    s1_valid_d = bus.i_valid & ~bus.i_clear;
    acc_sum_d  = acc_sum_q;
    acc_diff_d = acc_diff_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    err_d      = err_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;

    if (bus.i_valid) begin
      sum_d  = $signed({bus.i_channel_a[DATA_SIZE-1], bus.i_channel_a})
             + $signed({bus.i_channel_b[DATA_SIZE-1], bus.i_channel_b});
      diff_d = $signed({bus.i_channel_a[DATA_SIZE-1], bus.i_channel_a})
             - $signed({bus.i_channel_b[DATA_SIZE-1], bus.i_channel_b});
    end

    tot_sum  = acc_sum_q + AW'(sum_q);
    tot_diff = acc_diff_q + AW'(diff_q);
    res_sum  = tot_sum >>> AVG_LOG2;
    res_diff = tot_diff >>> AVG_LOG2;
    {sat_sum, clip_sum}   = clamp(res_sum);
    {sat_diff, clip_diff} = clamp(res_diff);

    if (bus.i_clear) begin
      acc_sum_d  = '0;
      acc_diff_d = '0;
      cnt_d      = '0;
    end else if (s1_valid_q) begin
      if (cnt_q == CNT_LAST) begin
        ref_d      = clip_sum;
        err_d      = clip_diff;
        sat_d      = sat_sum | sat_diff;
        valid_d    = 1'b1;
        acc_sum_d  = '0;
        acc_diff_d = '0;
        cnt_d      = '0;
      end else begin
        acc_sum_d  = tot_sum;
        acc_diff_d = tot_diff;
        cnt_d      = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sum_q      <= '0;
      diff_q     <= '0;
      s1_valid_q <= 1'b0;
      acc_sum_q  <= '0;
      acc_diff_q <= '0;
      cnt_q      <= '0;
      ref_q      <= '0;
      err_q      <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      s1_valid_q <= s1_valid_d;
      acc_sum_q  <= acc_sum_d;
      acc_diff_q <= acc_diff_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_reference = ref_q;
  assign bus.o_error     = err_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_saturated = sat_q;
endmodule

// File: tb/tb_monopulse_comparator.sv
// Bench for monopulse_comparator: two 8-bit instances (block length 1 and 4) share one
// stimulus stream; a block-level integer model predicts each result and its cycle.
module tb_monopulse_comparator;
  localparam int DS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  monopulse_comparator_if #(.DATA_SIZE(DS)) bus0 ();
  monopulse_comparator_if #(.DATA_SIZE(DS)) bus2 ();

  monopulse_comparator #(.DATA_SIZE(DS), .AVG_LOG2(0)) dut0 (
    .i_clock(clk), .i_reset(rst_n), .bus(bus0)
  );
  monopulse_comparator #(.DATA_SIZE(DS), .AVG_LOG2(2)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .bus(bus2)
  );

  // Entry layout: {due_cycle[31:0], saturated, reference[7:0], error[7:0]}
  logic [48:0] exp_q0[$];
  logic [48:0] exp_q2[$];
  int          blk_len[2] = '{1, 4};
  bit          pend_v[2];
  int          pend_a[2], pend_b[2], blk_sum[2], blk_dif[2], blk_n[2];
  logic [16:0] last_v[2] = '{17'd0, 17'd0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int fdiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic emit(input int d, input int at);
    int r, e;
    bit sat;
    logic [31:0] atv;
    r = fdiv(blk_sum[d], blk_len[d]);
    e = fdiv(blk_dif[d], blk_len[d]);
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    if (e > 127) begin e = 127; sat = 1'b1; end
    else if (e < -128) begin e = -128; sat = 1'b1; end
    atv = at;
    if (d == 0) exp_q0.push_back({atv, sat, r[7:0], e[7:0]});
    else        exp_q2.push_back({atv, sat, r[7:0], e[7:0]});
  endtask

  // A sample presented now is taken at the next edge and joins its block one edge
  // later, so a clear on the following cycle still discards it.
  task automatic model_step(input int d, input bit v, input int a, input int b, input bit clr);
    if (clr) begin
      pend_v[d] = 1'b0;
      blk_n[d] = 0; blk_sum[d] = 0; blk_dif[d] = 0;
    end else begin
      if (pend_v[d]) begin
        blk_sum[d] += pend_a[d] + pend_b[d];
        blk_dif[d] += pend_a[d] - pend_b[d];
        blk_n[d]++;
        if (blk_n[d] == blk_len[d]) begin
          emit(d, cyc + 1);
          blk_n[d] = 0; blk_sum[d] = 0; blk_dif[d] = 0;
        end
      end
      pend_v[d] = v; pend_a[d] = a; pend_b[d] = b;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend_v[d] = 1'b0; blk_n[d] = 0; blk_sum[d] = 0; blk_dif[d] = 0;
      last_v[d] = '0;
    end
    exp_q0.delete();
    exp_q2.delete();
  endtask

  task automatic set_in(input bit v, input int a, input int b, input bit clr);
    bus0.i_valid = v; bus0.i_channel_a = a[7:0]; bus0.i_channel_b = b[7:0]; bus0.i_clear = clr;
    bus2.i_valid = v; bus2.i_channel_a = a[7:0]; bus2.i_channel_b = b[7:0]; bus2.i_clear = clr;
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit clr);
    @(posedge clk);
    #1;
    set_in(v, a, b, clr);
    model_step(0, v, a, b, clr);
    model_step(1, v, a, b, clr);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ref0"}, int'(bus0.o_reference), 0);
    chk({tag, "_err0"}, int'(bus0.o_error), 0);
    chk({tag, "_val0"}, int'(bus0.o_valid), 0);
    chk({tag, "_sat0"}, int'(bus0.o_saturated), 0);
    chk({tag, "_ref2"}, int'(bus2.o_reference), 0);
    chk({tag, "_err2"}, int'(bus2.o_error), 0);
    chk({tag, "_val2"}, int'(bus2.o_valid), 0);
    chk({tag, "_sat2"}, int'(bus2.o_saturated), 0);
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] r,
                     input logic [7:0] e, input logic s);
    logic [48:0] ent;
    int n, due;
    n = (d == 0) ? exp_q0.size() : exp_q2.size();
    due = -1;
    ent = '0;
    if (n > 0) begin
      ent = (d == 0) ? exp_q0[0] : exp_q2[0];
      due = int'(ent[48:17]);
    end
    if (v || (n > 0 && due <= cyc)) begin
      chk($sformatf("valid%0d", d), int'(v), 1);
      if (n == 0) chk($sformatf("queued%0d", d), n, 1);
      else begin
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q2.pop_front());
        chk($sformatf("latency%0d", d), cyc, due);
        chk($sformatf("ref%0d", d), int'($signed(r)), int'($signed(ent[15:8])));
        chk($sformatf("err%0d", d), int'($signed(e)), int'($signed(ent[7:0])));
        chk($sformatf("sat%0d", d), int'(s), int'(ent[16]));
        last_v[d] = ent[16:0];
      end
    end else begin
      chk($sformatf("hold_ref%0d", d), int'($signed(r)), int'($signed(last_v[d][15:8])));
      chk($sformatf("hold_err%0d", d), int'($signed(e)), int'($signed(last_v[d][7:0])));
      chk($sformatf("hold_sat%0d", d), int'(s), int'(last_v[d][16]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.o_valid, bus0.o_reference, bus0.o_error, bus0.o_saturated);
      mon(1, bus2.o_valid, bus2.o_reference, bus2.o_error, bus2.o_saturated);
    end
  end

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_reset_hold");
    set_in(1'b0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    model_reset();
    set_in(1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      set_in(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1) == 1);
      @(negedge clk);
      chk_zero("reset");
    end
    set_in(1'b0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0);

    // Plain sums/differences, back-to-back samples and both saturation rails
    drive(1, 10, 3, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 1, 2, 0);
    drive(1, 5, -7, 0);
    drive(1, 100, 100, 0);
    drive(1, -128, 100, 0);
    drive(0, 0, 0, 0);
    drive(1, 77, 11, 1);
    drive(0, 0, 0, 0);

    // Averaging, including floor rounding of a negative total
    drive(1, 4, 0, 0);  drive(1, 8, 0, 0);  drive(1, 12, 0, 0); drive(1, 16, 2, 0);
    drive(1, 0, 1, 0);  drive(1, 0, 1, 0);  drive(1, 0, 1, 0);  drive(1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Same block spread out with idle cycles
    drive(1, 4, 0, 0);  drive(0, 0, 0, 0);
    drive(1, 8, 0, 0);  drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    drive(1, 12, 0, 0); drive(0, 0, 0, 0);
    drive(1, 16, 2, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Flush mid-block with a sample colliding with the clear
    drive(1, 1, 1, 0);  drive(1, 2, 2, 0);  drive(1, 50, 50, 1);
    drive(1, 3, 1, 0);  drive(1, 5, 1, 0);  drive(1, 7, 1, 0); drive(1, 9, 1, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Reset mid-block, then a fresh block
    drive(1, 20, 20, 0); drive(1, 30, 30, 0);
    drive(0, 0, 0, 0);   drive(0, 0, 0, 0);
    mid_reset();
    drive(1, -3, 4, 0);  drive(1, -60, 70, 0); drive(1, 90, -90, 0); drive(1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Randomised traffic with gaps and occasional clears
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive($urandom_range(0, 9) < 7, int'($signed(ra)), int'($signed(rb)),
            $urandom_range(0, 19) == 0);
    end

    repeat (4) drive(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("drain0", exp_q0.size(), 0);
    chk("drain2", exp_q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
